// File: rtl/pipe_out_arbiter.sv
// rtl/pipe_out_arbiter.sv - round-robin block arbiter feeding a BTPipeOut (optional PIPE_ARB_STATS_EN)
module pipe_out_arbiter #(
   parameter int N_SRC       = 4,
   parameter int BLOCK_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [N_SRC*11-1:0]   src_level,
   input  logic [N_SRC*32-1:0]   src_data,
   output logic [N_SRC-1:0]      src_rd,
   output logic                  ep_ready,
   input  logic                  ep_blockstrobe,
   input  logic                  ep_read,
   output logic [31:0]           ep_datain,
   output logic [2:0]            grant_id,
   input  logic                  err_clr,
   output logic                  err_read,
   output logic                  err_strobe
`ifdef PIPE_ARB_STATS_EN
   ,
   output logic [N_SRC*32-1:0]   blk_count
`endif
);

   localparam int CW = $clog2(BLOCK_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT, S_XFER} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      grant_q, grant_d;
   logic [2:0]      last_q, last_d;
   logic            ready_q, ready_d;
   logic            err_read_q, err_read_d;
   logic            err_strobe_q, err_strobe_d;
   logic [N_SRC-1:0] qual;
   logic            found;
   logic [2:0]      pick;
   logic            blk_done;

   assign blk_done = (state_q == S_XFER) && ep_read && (cnt_q == {CW{1'b1}});

   // Flag every source holding at least one full block.
   always_comb begin
      qual = '0;
      for (int j = 0; j < N_SRC; j++) begin
         qual[j] = (src_level[11*j +: 11] >= 11'(BLOCK_WORDS));
      end
   end

   // Round-robin search from last_grant+1; scanning k downward leaves the nearest hit.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = N_SRC; k >= 1; k--) begin
         for (int j = 0; j < N_SRC; j++) begin
            if (qual[j] && (((int'(last_q) + k) % N_SRC) == j)) begin
               found = 1'b1;
               pick  = 3'(j);
            end
         end
      end
   end

   // Next-state, counter, grant and sticky-error logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_ARB;
         end
         S_ARB: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (found) begin
               grant_d = pick;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (ep_blockstrobe) begin
               state_d = S_XFER;
               cnt_d   = '0;
            end
         end
         S_XFER: begin
            if (ep_read) cnt_d = cnt_q + CW'(1);
            if (blk_done) begin
               last_d  = grant_q;
               state_d = enable ? S_ARB : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ready_d      = (state_d == S_WAIT);
      err_read_d   = (ep_read && state_q != S_XFER) ? 1'b1 : (err_clr ? 1'b0 : err_read_q);
      err_strobe_d = (ep_blockstrobe && state_q != S_WAIT) ? 1'b1 : (err_clr ? 1'b0 : err_strobe_q);
   end

   // State registers; reset leaves last_grant at N_SRC-1 so the first search starts at 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         grant_q      <= '0;
         last_q       <= 3'(N_SRC - 1);
         ready_q      <= 1'b0;
         err_read_q   <= 1'b0;
         err_strobe_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_q       <= last_d;
         ready_q      <= ready_d;
         err_read_q   <= err_read_d;
         err_strobe_q <= err_strobe_d;
      end
   end

   // Route the endpoint read strobe to the granted FIFO and its data back out.
   always_comb begin
      src_rd    = '0;
      ep_datain = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q == 3'(i)) begin
            src_rd[i] = (state_q == S_XFER) && ep_read;
            ep_datain = src_data[32*i +: 32];
         end
      end
   end

   assign ep_ready   = ready_q;
   assign grant_id   = grant_q;
   assign err_read   = err_read_q;
   assign err_strobe = err_strobe_q;

`ifdef PIPE_ARB_STATS_EN
   logic [31:0] blk_cnt_q [N_SRC];

   // Per-source completed-block counters, wrapping at 2^32.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_SRC; i++) blk_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (blk_done && grant_q == 3'(i)) blk_cnt_q[i] <= blk_cnt_q[i] + 32'd1;
         end
      end
   end

   // Pack the counters onto the flat output bus.
   always_comb begin
      blk_count = '0;
      for (int i = 0; i < N_SRC; i++) blk_count[32*i +: 32] = blk_cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// tb/tb_pipe_out_arbiter.sv - directed self-checking bench for pipe_out_arbiter
module tb_pipe_out_arbiter;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            enable = 1'b0;
   logic [N*11-1:0] src_level;
   logic [N*32-1:0] src_data;
   logic [N-1:0]    src_rd;
   logic            ep_ready;
   logic            ep_blockstrobe = 1'b0;
   logic            ep_read = 1'b0;
   logic [31:0]     ep_datain;
   logic [2:0]      grant_id;
   logic            err_clr = 1'b0;
   logic            err_read;
   logic            err_strobe;
`ifdef PIPE_ARB_STATS_EN
   logic [N*32-1:0] blk_count;
`endif

   logic [10:0] lvl [N];
   logic [31:0] ptr [N];
   logic [31:0] data_q [N];
   logic        fifo_clr = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_out_arbiter #(.N_SRC(N), .BLOCK_WORDS(256)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .enable         (enable),
      .src_level      (src_level),
      .src_data       (src_data),
      .src_rd         (src_rd),
      .ep_ready       (ep_ready),
      .ep_blockstrobe (ep_blockstrobe),
      .ep_read        (ep_read),
      .ep_datain      (ep_datain),
      .grant_id       (grant_id),
      .err_clr        (err_clr),
      .err_read       (err_read),
      .err_strobe     (err_strobe)
`ifdef PIPE_ARB_STATS_EN
      ,
      .blk_count      (blk_count)
`endif
   );

   always #5 clk = ~clk;

   // FIFO model: word of source i is {i, 0x001000 + index}, valid the cycle after src_rd.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (fifo_clr) begin
            ptr[i]    <= 32'd0;
            data_q[i] <= 32'd0;
         end else if (src_rd[i]) begin
            data_q[i] <= (32'(i) << 24) | (32'h1000 + ptr[i]);
            ptr[i]    <= ptr[i] + 32'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         src_level[11*i +: 11] = lvl[i];
         src_data[32*i +: 32]  = data_q[i];
      end
   end

   task automatic set_levels(input int l0, input int l1, input int l2, input int l3);
      lvl[0] = 11'(l0);
      lvl[1] = 11'(l1);
      lvl[2] = 11'(l2);
      lvl[3] = 11'(l3);
   endtask

   task automatic apply_reset(input logic en_after);
      @(negedge clk);
      reset_n = 1'b0;
      enable = 1'b0;
      ep_read = 1'b0;
      ep_blockstrobe = 1'b0;
      err_clr = 1'b0;
      fifo_clr = 1'b1;
      repeat (2) @(negedge clk);
      fifo_clr = 1'b0;
      reset_n = 1'b1;
      enable = en_after;
   endtask

   task automatic wait_ready(input int exp_grant);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!ep_ready && cyc < 20);
      n_cmp++;
      if (ep_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL wait_ready: ep_ready=%b after %0d cycles, required 1", ep_ready, cyc);
      end
      n_cmp++;
      if (grant_id !== 3'(exp_grant)) begin
         n_bad++;
         $display("FAIL grant_id: got %0d required %0d", grant_id, exp_grant);
      end
   endtask

   task automatic pulse_strobe();
      ep_blockstrobe = 1'b1;
      @(negedge clk);
      ep_blockstrobe = 1'b0;
   endtask

   task automatic read_words(input int src, input int n, input int first);
      logic [31:0] exp_d;
      logic [N-1:0] exp_rd;
      exp_rd = N'(1 << src);
      for (int w = 0; w < n; w++) begin
         @(negedge clk);
         if (w > 0) begin
            exp_d = (32'(src) << 24) | (32'h1000 + 32'(first + w - 1));
            n_cmp++;
            if (ep_datain !== exp_d) begin
               n_bad++;
               $display("FAIL ep_datain src %0d word %0d: got %h required %h", src, first + w - 1, ep_datain, exp_d);
            end
         end
         ep_read = 1'b1;
         #1;
         n_cmp++;
         if (src_rd !== exp_rd) begin
            n_bad++;
            $display("FAIL src_rd src %0d word %0d: got %b required %b", src, first + w, src_rd, exp_rd);
         end
      end
      @(negedge clk);
      ep_read = 1'b0;
      exp_d = (32'(src) << 24) | (32'h1000 + 32'(first + n - 1));
      n_cmp++;
      if (ep_datain !== exp_d) begin
         n_bad++;
         $display("FAIL ep_datain src %0d last word: got %h required %h", src, ep_datain, exp_d);
      end
   endtask

   task automatic test_reset();
      set_levels(0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b0;
      fifo_clr = 1'b1;
      #1;
      n_cmp++;
      if (ep_ready !== 1'b0) begin n_bad++; $display("FAIL reset ep_ready: got %b required 0", ep_ready); end
      n_cmp++;
      if (grant_id !== 3'd0) begin n_bad++; $display("FAIL reset grant_id: got %0d required 0", grant_id); end
      n_cmp++;
      if (src_rd !== '0) begin n_bad++; $display("FAIL reset src_rd: got %b required 0", src_rd); end
      n_cmp++;
      if (err_read !== 1'b0) begin n_bad++; $display("FAIL reset err_read: got %b required 0", err_read); end
      n_cmp++;
      if (err_strobe !== 1'b0) begin n_bad++; $display("FAIL reset err_strobe: got %b required 0", err_strobe); end
      @(negedge clk);
      fifo_clr = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_first_grant();
      set_levels(0, 0, 300, 0);
      apply_reset(1'b1);
      @(negedge clk);
      n_cmp++;
      if (ep_ready !== 1'b0) begin n_bad++; $display("FAIL first_grant ready early: got %b required 0", ep_ready); end
      @(negedge clk);
      n_cmp++;
      if (ep_ready !== 1'b1) begin n_bad++; $display("FAIL first_grant ep_ready: got %b required 1", ep_ready); end
      n_cmp++;
      if (grant_id !== 3'd2) begin n_bad++; $display("FAIL first_grant grant_id: got %0d required 2", grant_id); end
      enable = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ep_ready !== 1'b0) begin n_bad++; $display("FAIL disable_wait ep_ready: got %b required 0", ep_ready); end
      pulse_strobe();
      n_cmp++;
      if (err_strobe !== 1'b1) begin n_bad++; $display("FAIL idle_strobe err_strobe: got %b required 1", err_strobe); end
   endtask

   task automatic test_round_robin();
`ifdef PIPE_ARB_STATS_EN
      logic [N*32-1:0] exp_cnt;
`endif
      set_levels(256, 256, 256, 256);
      apply_reset(1'b1);
      for (int b = 0; b < N; b++) begin
         wait_ready(b);
         pulse_strobe();
         read_words(b, 256, 0);
      end
`ifdef PIPE_ARB_STATS_EN
      for (int i = 0; i < N; i++) exp_cnt[32*i +: 32] = 32'd1;
      n_cmp++;
      if (blk_count !== exp_cnt) begin n_bad++; $display("FAIL blk_count: got %h required %h", blk_count, exp_cnt); end
`endif
   endtask

   task automatic test_errors();
      set_levels(0, 256, 0, 0);
      apply_reset(1'b1);
      wait_ready(1);
      ep_read = 1'b1;
      #1;
      n_cmp++;
      if (src_rd !== '0) begin n_bad++; $display("FAIL wait_read src_rd: got %b required 0", src_rd); end
      @(negedge clk);
      ep_read = 1'b0;
      n_cmp++;
      if (err_read !== 1'b1) begin n_bad++; $display("FAIL wait_read err_read: got %b required 1", err_read); end
      n_cmp++;
      if (ep_ready !== 1'b1) begin n_bad++; $display("FAIL wait_read ep_ready: got %b required 1", ep_ready); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_cmp++;
      if (err_read !== 1'b0) begin n_bad++; $display("FAIL err_clr err_read: got %b required 0", err_read); end
      pulse_strobe();
      n_cmp++;
      if (err_strobe !== 1'b0) begin n_bad++; $display("FAIL wait_strobe err_strobe: got %b required 0", err_strobe); end
      ep_blockstrobe = 1'b1;
      err_clr = 1'b1;
      @(negedge clk);
      ep_blockstrobe = 1'b0;
      err_clr = 1'b0;
      n_cmp++;
      if (err_strobe !== 1'b1) begin n_bad++; $display("FAIL set_wins err_strobe: got %b required 1", err_strobe); end
      read_words(1, 256, 0);
      n_cmp++;
      if (err_read !== 1'b0) begin n_bad++; $display("FAIL xfer err_read: got %b required 0", err_read); end
   endtask

   task automatic test_enable_drop();
      set_levels(256, 256, 256, 256);
      apply_reset(1'b1);
      wait_ready(0);
      pulse_strobe();
      read_words(0, 100, 0);
      enable = 1'b0;
      set_levels(0, 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (grant_id !== 3'd0) begin n_bad++; $display("FAIL level_change grant_id: got %0d required 0", grant_id); end
      read_words(0, 156, 100);
      set_levels(256, 256, 256, 256);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (ep_ready !== 1'b0) begin n_bad++; $display("FAIL after_drop ep_ready cycle %0d: got %b required 0", c, ep_ready); end
      end
   endtask

   task automatic test_reset_mid();
      set_levels(256, 256, 256, 256);
      apply_reset(1'b1);
      wait_ready(0);
      pulse_strobe();
      read_words(0, 50, 0);
      @(negedge clk);
      ep_read = 1'b1;
      #1;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (src_rd !== '0) begin n_bad++; $display("FAIL reset_mid src_rd: got %b required 0", src_rd); end
      n_cmp++;
      if (ep_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mid ep_ready: got %b required 0", ep_ready); end
      n_cmp++;
      if (grant_id !== 3'd0) begin n_bad++; $display("FAIL reset_mid grant_id: got %0d required 0", grant_id); end
`ifdef PIPE_ARB_STATS_EN
      n_cmp++;
      if (blk_count !== '0) begin n_bad++; $display("FAIL reset_mid blk_count: got %h required 0", blk_count); end
`endif
      @(negedge clk);
      ep_read = 1'b0;
      enable = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (ep_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mid idle ep_ready: got %b required 0", ep_ready); end
      n_cmp++;
      if (err_read !== 1'b0) begin n_bad++; $display("FAIL reset_mid err_read: got %b required 0", err_read); end
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_round_robin();
      test_errors();
      test_enable_drop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
